// File: rtl/bus_pkg.sv
// Definitions shared by the bus terminals, the arbiter and the scoreboard:
// the destination-ID field layout and a helper to extract it from a packet.
package bus_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_ID = 8'hFF;

  // Default packet width used by the bus slice; instances may override
  // their own pckg_sz parameter, while pkt_t covers the common case.
  localparam int PKT_W = 16;
  typedef logic [PKT_W-1:0] pkt_t;

  // Destination ID sits in the top ID_W bits of every packet.
  function automatic logic [ID_W-1:0] pkt_id(input pkt_t pkt);
    return pkt[PKT_W-1 -: ID_W];
  endfunction

endpackage

// File: rtl/tx_fifo_mem.sv
// Storage array for the transmit FIFO: depth x pckg_sz registers with one
// clocked write port and one combinational read port. Contents are never
// reset; the control logic decides when an entry is meaningful.
module tx_fifo_mem
  import bus_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(depth)-1:0] wr_addr,
  input  logic [pckg_sz-1:0]       wr_data,
  input  logic [$clog2(depth)-1:0] rd_addr,
  output logic [pckg_sz-1:0]       rd_data
);

  localparam int AW = $clog2(depth);

  logic [pckg_sz-1:0] mem_reg [depth];

  genvar gi;
  generate
    for (gi = 0; gi < depth; gi++) begin : g_entry
      // Each entry captures the write data when it is the addressed slot.
      always_ff @(posedge clk) begin
        if (wr_en && (wr_addr == AW'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Show-ahead read of the slot at the read pointer.
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/bus_term_tx_fifo.sv
// Per-terminal transmit FIFO feeding the bus arbiter through the
// pndng/pop/D_pop handshake. Head packet is presented show-ahead.
// Optional feature macro: TX_FIFO_OVF_CNT_EN adds a saturating 8-bit
// count of dropped pushes on output ovf_cnt.
// depth must be a power of two and at least 2 so the pointers wrap
// naturally at their bit width.
module bus_term_tx_fifo
  import bus_pkg::*;
#(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [pckg_sz-1:0]         D_push,
  output logic                       full,
  output logic                       pndng,
  output logic [pckg_sz-1:0]         D_pop,
  input  logic                       pop,
  output logic [$clog2(depth):0]     count,
`ifdef TX_FIFO_OVF_CNT_EN
  output logic [7:0]                 ovf_cnt,
`endif
  output logic                       ovf
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]      count_reg, count_next;
  logic               ovf_reg, ovf_next;
  logic               wr_en;
  logic               rd_en;
  logic [pckg_sz-1:0] rd_data;

  // Status flags come straight from the registered occupancy.
  assign full  = (count_reg == DEPTH_C);
  assign pndng = (count_reg != '0);
  assign count = count_reg;
  assign ovf   = ovf_reg;

  // Force the head to zero while empty so reset shows a clean D_pop even
  // though the storage itself is never cleared.
  assign D_pop = pndng ? rd_data : '0;

  tx_fifo_mem #(
    .pckg_sz (pckg_sz),
    .depth   (depth)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (D_push),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // Handshake decode and next-state for pointers, occupancy and overflow.
  always_comb begin
    wr_en       = push && (!full || pop);
    rd_en       = pop && pndng;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    ovf_next    = push && full && !pop;
    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    if (wr_en && !rd_en) begin
      count_next = count_reg + 1'b1;
    end else if (rd_en && !wr_en) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Control state register; asynchronous clear discards all queued packets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

`ifdef TX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_reg;

  // Saturating tally of dropped pushes, updated alongside the ovf pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_cnt_reg <= '0;
    end else if (ovf_next && (ovf_cnt_reg != 8'hFF)) begin
      ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_reg;
`endif

endmodule

// File: tb/tb_bus_term_tx_fifo.sv
// Self-checking bench for bus_term_tx_fifo. A queue-based model tracks the
// expected FIFO contents; each scenario task compares DUT outputs inline.
// Honours TX_FIFO_OVF_CNT_EN when defined.
module tb_bus_term_tx_fifo;

  localparam int W     = 16;
  localparam int DEPTH = 8;

  logic         clk;
  logic         reset;
  logic         push;
  logic [W-1:0] D_push;
  logic         full;
  logic         pndng;
  logic [W-1:0] D_pop;
  logic         pop;
  logic [3:0]   count;
  logic         ovf;
`ifdef TX_FIFO_OVF_CNT_EN
  logic [7:0]   ovf_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  bit           exp_ovf;
  int           exp_ovf_cnt;

  bus_term_tx_fifo #(.pckg_sz(W), .depth(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .D_push  (D_push),
    .full    (full),
    .pndng   (pndng),
    .D_pop   (D_pop),
    .pop     (pop),
    .count   (count),
`ifdef TX_FIFO_OVF_CNT_EN
    .ovf_cnt (ovf_cnt),
`endif
    .ovf     (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus; the model applies the FIFO rules directly.
  task automatic cycle(input bit p, input logic [W-1:0] d, input bit o);
    bit acc;
    bit ep;
    push   = p;
    D_push = d;
    pop    = o;
    ep      = o && (q.size() != 0);
    acc     = p && ((q.size() < DEPTH) || o);
    exp_ovf = p && (q.size() == DEPTH) && !o;
    if (exp_ovf && exp_ovf_cnt < 255) exp_ovf_cnt++;
    @(posedge clk);
    if (ep) void'(q.pop_front());
    if (acc) q.push_back(d);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    $display("cycle push=%0b d=%h pop=%0b -> count=%0d pndng=%0b D_pop=%h ovf=%0b",
             p, d, o, count, pndng, D_pop, ovf);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    push = 1'b0; pop = 1'b0; D_push = '0;
    q.delete();
    exp_ovf = 0; exp_ovf_cnt = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL reset_pndng got=%b exp=0", pndng); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (D_pop !== 16'h0) begin failures++; $display("FAIL reset_dpop got=%h exp=0000", D_pop); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`ifdef TX_FIFO_OVF_CNT_EN
    checks++; if (ovf_cnt !== 8'h00) begin failures++; $display("FAIL reset_ovf_cnt got=%h exp=00", ovf_cnt); end
`endif
  endtask

  task automatic test_single();
    cycle(1'b1, 16'h03A5, 1'b0);
    checks++; if (pndng !== 1'b1) begin failures++; $display("FAIL single_pndng got=%b exp=1", pndng); end
    checks++; if (D_pop !== 16'h03A5) begin failures++; $display("FAIL single_dpop got=%h exp=03a5", D_pop); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
    cycle(1'b0, 16'h0, 1'b1);
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL single_pop_pndng got=%b exp=0", pndng); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL single_pop_count got=%0d exp=0", count); end
  endtask

  task automatic test_fill_ovf();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 16'h0100 + 16'(i), 1'b0);
      checks++; if (count !== 4'(q.size())) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, q.size()); end
    end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b exp=1", full); end
    cycle(1'b1, 16'hFFEE, 1'b0);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_pulse got=%b exp=1", ovf); end
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", count); end
    cycle(1'b0, 16'h0, 1'b0);
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_one_cycle got=%b exp=0", ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (D_pop !== 16'h0100 + 16'(i)) begin failures++; $display("FAIL drain_order got=%h exp=%h", D_pop, 16'h0100 + 16'(i)); end
      cycle(1'b0, 16'h0, 1'b1);
    end
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", pndng); end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] last;
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'($urandom), 1'b0);
    cycle(1'b1, 16'h0A0A, 1'b1);
    checks++; if (count !== 4'd8) begin failures++; $display("FAIL simul_full_count got=%0d exp=8", count); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL simul_full_ovf got=%b exp=0", ovf); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL simul_full_flag got=%b exp=1", full); end
    last = '0;
    while (q.size() != 0) begin
      checks++; if (D_pop !== q[0]) begin failures++; $display("FAIL simul_drain got=%h exp=%h", D_pop, q[0]); end
      last = D_pop;
      cycle(1'b0, 16'h0, 1'b1);
    end
    checks++; if (last !== 16'h0A0A) begin failures++; $display("FAIL simul_last got=%h exp=0a0a", last); end
    cycle(1'b1, 16'h5C5C, 1'b1);
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL simul_empty_count got=%0d exp=1", count); end
    checks++; if (D_pop !== 16'h5C5C) begin failures++; $display("FAIL simul_empty_dpop got=%h exp=5c5c", D_pop); end
    cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_wrap();
    bit p;
    bit o;
    int pairs;
    pairs = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0);
    while (pairs < 20) begin
      if (q.size() <= 1) begin p = 1; o = 0; end
      else if (q.size() >= 7) begin p = 0; o = 1; end
      else begin p = 1'($urandom); o = 1'($urandom); end
      if (p && o) pairs++;
      if (o) begin
        checks++; if (D_pop !== q[0]) begin failures++; $display("FAIL wrap_head got=%h exp=%h", D_pop, q[0]); end
      end
      cycle(p, 16'($urandom), o);
      checks++; if (count !== 4'(q.size())) begin failures++; $display("FAIL wrap_count got=%0d exp=%0d", count, q.size()); end
    end
    while (q.size() != 0) begin
      checks++; if (D_pop !== q[0]) begin failures++; $display("FAIL wrap_drain got=%h exp=%h", D_pop, q[0]); end
      cycle(1'b0, 16'h0, 1'b1);
    end
  endtask

  task automatic test_random();
    bit p;
    bit o;
    for (int i = 0; i < 300; i++) begin
      p = ($urandom_range(99) < 60);
      o = ($urandom_range(99) < 45);
      cycle(p, 16'($urandom), o);
      checks++; if (count !== 4'(q.size())) begin failures++; $display("FAIL rand_count got=%0d exp=%0d", count, q.size()); end
      checks++; if (ovf !== exp_ovf) begin failures++; $display("FAIL rand_ovf got=%b exp=%b", ovf, exp_ovf); end
      checks++; if (full !== (q.size() == DEPTH)) begin failures++; $display("FAIL rand_full got=%b exp=%b", full, q.size() == DEPTH); end
      checks++; if (pndng !== (q.size() != 0)) begin failures++; $display("FAIL rand_pndng got=%b exp=%b", pndng, q.size() != 0); end
      if (q.size() != 0) begin
        checks++; if (D_pop !== q[0]) begin failures++; $display("FAIL rand_dpop got=%h exp=%h", D_pop, q[0]); end
      end
    end
  endtask

  task automatic test_ovf_cnt();
`ifdef TX_FIFO_OVF_CNT_EN
    while (q.size() < DEPTH) cycle(1'b1, 16'($urandom), 1'b0);
    for (int i = 0; i < 300; i++) cycle(1'b1, 16'($urandom), 1'b0);
    checks++; if (ovf_cnt !== 8'(exp_ovf_cnt)) begin failures++; $display("FAIL ovf_cnt_model got=%h exp=%h", ovf_cnt, exp_ovf_cnt); end
    checks++; if (ovf_cnt !== 8'hFF) begin failures++; $display("FAIL ovf_cnt_sat got=%h exp=ff", ovf_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    while (q.size() != 0) cycle(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'($urandom), 1'b0);
    #2 reset = 1'b0;
    #1;
    q.delete();
    exp_ovf_cnt = 0;
    checks++; if (pndng !== 1'b0) begin failures++; $display("FAIL mid_reset_pndng got=%b exp=0", pndng); end
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL mid_reset_count got=%0d exp=0", count); end
    checks++; if (D_pop !== 16'h0) begin failures++; $display("FAIL mid_reset_dpop got=%h exp=0000", D_pop); end
`ifdef TX_FIFO_OVF_CNT_EN
    checks++; if (ovf_cnt !== 8'h00) begin failures++; $display("FAIL mid_reset_ovf_cnt got=%h exp=00", ovf_cnt); end
`endif
    #1 reset = 1'b1;
    cycle(1'b1, 16'h0201, 1'b0);
    checks++; if (D_pop !== 16'h0201) begin failures++; $display("FAIL post_reset_dpop got=%h exp=0201", D_pop); end
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL post_reset_count got=%0d exp=1", count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_ovf();
    test_simultaneous();
    test_wrap();
    test_random();
    test_ovf_cnt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_term_tx_fifo.md
# bus_term_tx_fifo

Per-terminal transmit FIFO that sits directly upstream of the bus generator/arbiter, one instance per driver slot. It buffers packets written by the terminal (agent/driver side) and presents the head packet to the arbiter. It uses the arbiter's `pndng`/`pop`/`D_pop` handshake. Instances are bit-sliced onto the arbiter's `pndng[i]`, `pop[i]` and `D_pop[i]` vectors.

## Interface
- `pckg_sz`, 16: packet width in bits; bits `[pckg_sz-1 -: 8]` hold the destination ID, and `8'hFF` means broadcast.
- `depth`, 8: number of FIFO entries; must be a power of two, at least 2.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `push`  in  1: terminal write strobe, sampled at the rising edge.
- `D_push`  in  `pckg_sz`: packet to write; valid while `push` is high.
- `full`  out  1: high when `count == depth`.
- `pndng`  out  1: high when `count != 0`; this is the arbiter's request line.
- `D_pop`  out  `pckg_sz`: head packet, show-ahead; valid whenever `pndng` is high.
- `pop`  in  1: arbiter consume strobe; removes the head entry at the rising edge.
- `count`  out  `$clog2(depth)+1`: current occupancy.
- `ovf`  out  1: one-cycle pulse when a push is dropped.

## Operation
- Circular buffer with read and write pointers, each `$clog2(depth)` bits wide, wrapping modulo `depth`. A separate occupancy counter drives `full`, `pndng` and `count`.
- **Accepted write:** `push && (!full || pop)` stores `D_push` at the write pointer, then increments the write pointer.
- **Effective pop:** `pop && pndng` increments the read pointer. A pop while empty is ignored; no pointer or counter changes.
- **Count update:** `+1` on an accepted write only, `-1` on an effective pop only, unchanged when both or neither occur.
- **Full with push and pop together:** both take effect, `count` stays at `depth`, and `ovf` stays low.
- **Empty with push and pop together:** the pop is ignored, the write is accepted, and `count` becomes 1.
- **Overflow:** `push` while full with no `pop` drops the packet. `ovf` pulses high for that one cycle, and memory and pointers are unchanged.
- `D_pop` is driven from the memory at the read pointer; its value is don't-care while `pndng` is low.
- Packet contents are not interpreted. The ID field is stored verbatim, including broadcast `8'hFF`.

## Timing
- **Reset asserted** (`reset` low, asynchronous):
  - pointers and `count` go to 0;
  - `pndng`=0, `full`=0, `ovf`=0;
  - `D_pop`=0;
  - memory contents are not reset.
- **Reset mid-operation:** all queued packets are discarded. After release, the FIFO behaves as empty from the first rising edge.
- **Write-to-pending latency:** 1 cycle. A push at edge N into an empty FIFO gives `pndng`=1 and `D_pop`=data after edge N.
- **Pop-to-next-head latency:** 0 extra cycles. After the edge that pops, `D_pop` shows the next entry, or `pndng` drops if the FIFO is now empty.
- Back-to-back push and pop every cycle sustain one packet per cycle at any occupancy.
- All outputs are registered or derived only from registered state; no combinational path exists from `push` or `pop` to any output.

## Configuration
- Macro: `TX_FIFO_OVF_CNT_EN`.
- **Defined:** adds output `ovf_cnt` (out, 8 bits).
  - Reset value 0.
  - Increments on every cycle where `ovf` pulses.
  - Saturates at `8'hFF`.
- **Undefined:** the port and counter are absent. `ovf` behaviour is identical in both builds.

## Structure
Package `bus_pkg` holds shared definitions:
- `ID_W = 8`;
- `BCAST_ID = 8'hFF`;
- a parameterised packet typedef helper;
- a function `pkt_id(pkt)` returning the top `ID_W` bits. The arbiter and the checker/scoreboard use this function; this block does not.

One sub-module, `tx_fifo_mem`:
- `depth` x `pckg_sz` register array;
- one synchronous write port;
- one asynchronous read port addressed by the read pointer.

All pointer, count and overflow logic lives in the top block.

## Test plan
- **Reset sanity:** hold `reset` low 3 cycles, then release → `pndng`=0, `full`=0, `count`=0, `D_pop`=0.
- **Single packet:** push `16'h03A5` → after one edge `pndng`=1, `D_pop`=`16'h03A5`, `count`=1. Pop → `pndng`=0, `count`=0.
- **Fill and overflow** (`depth`=8): push `16'h0100`..`16'h0107` → `full`=1. Push `16'hFFEE` → `ovf` high one cycle and the packet is dropped. Eight pops return `16'h0100`..`16'h0107` in order, and `16'hFFEE` never appears on `D_pop`.
- **Simultaneous events:**
  - full, push `16'h0A0A` with pop → `count` stays 8, `ovf`=0, and `16'h0A0A` emerges last;
  - empty, push with pop → `count`=1.
- **Wrap-around:** 20 interleaved push/pop pairs with pseudo-random data, occupancy between 1 and 7 → output order matches input exactly across pointer wrap.
- **Reset mid-operation:** 5 packets queued, assert `reset` between edges → `pndng` drops immediately with no clock edge. After release, pushing `16'h0201` gives `D_pop`=`16'h0201`. With `TX_FIFO_OVF_CNT_EN`, 300 overflows give `ovf_cnt`=`8'hFF`.
